// File: rtl/exc_pkg.sv
// ============================================================================
// Module : exc_pkg
// Brief  : Shared cause codes, controller state encoding and kernel vector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package exc_pkg;

   typedef enum logic [2:0] {
      CAUSE_NONE    = 3'b000,
      CAUSE_OVF     = 3'b001,
      CAUSE_SYSCALL = 3'b010,
      CAUSE_IRQ     = 3'b011
   } cause_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TAKE   = 3'd1,
      KWAIT  = 3'd2,
      KERNEL = 3'd3,
      ERET   = 3'd4
   } exc_state_t;

   localparam logic [31:0] EXC_VECTOR_ADDR = 32'h0000_0080;

endpackage

`default_nettype wire

// File: rtl/irq_pending.sv
// ============================================================================
// Module : irq_pending
// Brief  : Sticky IRQ pending bits with lowest-index one-hot pick.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module irq_pending
   import exc_pkg::*;
#(
   parameter int IRQ_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IRQ_W-1:0] i_irq,
   input  logic [IRQ_W-1:0] i_ack,
   output logic [IRQ_W-1:0] o_pick
);

   logic [IRQ_W-1:0] r_pending;
   logic [IRQ_W-1:0] w_req;

   // A live request counts immediately so it can be taken the edge it is seen.
   assign w_req  = r_pending | i_irq;
   assign o_pick = w_req & (~w_req + IRQ_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_req & ~i_ack;
      end
   end

endmodule

`default_nettype wire

// File: rtl/exception_ctrl.sv
// ============================================================================
// Module : exception_ctrl
// Brief  : Arbitrates overflow/syscall/IRQ, drives CP0 cause pulse and eret.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module exception_ctrl
   import exc_pkg::*;
#(
   parameter int          IRQ_W       = 4,
   parameter logic [31:0] VECTOR_ADDR = EXC_VECTOR_ADDR,
   parameter int          ERET_GUARD  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IRQ_W-1:0] irq,
   output logic [IRQ_W-1:0] irq_ack,
   input  logic             overflowE,
   input  logic             syscallD,
   input  logic             eretD,
   input  logic             stallD,
   input  logic             kernel_mode,
   input  logic [31:0]      epc,
   output logic             cause_write,
   output logic [2:0]       int_cause,
   output logic             exit_kernel,
   output logic             flushF,
   output logic             flushD,
   output logic             flushE,
   output logic             pc_redirect,
   output logic [31:0]      pc_target,
   output logic             kernel_fault
);

   localparam int GW = $clog2(ERET_GUARD + 2);

   exc_state_t       r_state, w_state_nxt;
   cause_t           r_cause, w_cause_nxt;
   logic [IRQ_W-1:0] r_ack,   w_ack_nxt;
   logic [GW-1:0]    r_guard;
   logic             r_kfault;
   logic             w_fault_set;
   logic             w_sys_ok;
   logic             w_irq_ok;
   logic [IRQ_W-1:0] w_pick;

   irq_pending #(.IRQ_W(IRQ_W)) u_irq_pending (
      .clk    (clk),
      .reset  (reset),
      .i_irq  (irq),
      .i_ack  (r_ack),
      .o_pick (w_pick)
   );

   assign w_sys_ok = syscallD & ~stallD;
   assign w_irq_ok = kernel_mode & ~stallD & (r_guard == '0) & (|w_pick);

   always_comb begin
      w_state_nxt = r_state;
      w_cause_nxt = CAUSE_NONE;
      w_ack_nxt   = '0;
      w_fault_set = 1'b0;
      case (r_state)
         IDLE: begin
            if (overflowE) begin
               w_state_nxt = TAKE;
               w_cause_nxt = CAUSE_OVF;
            end else if (w_sys_ok) begin
               w_state_nxt = TAKE;
               w_cause_nxt = CAUSE_SYSCALL;
            end else if (w_irq_ok) begin
               w_state_nxt = TAKE;
               w_cause_nxt = CAUSE_IRQ;
               w_ack_nxt   = w_pick;
            end else if (eretD && !kernel_mode && !stallD) begin
               w_state_nxt = ERET;
            end
         end
         TAKE:   w_state_nxt = KWAIT;
         KWAIT:  if (!kernel_mode) w_state_nxt = KERNEL;
         KERNEL: begin
            // Nested exceptions are only recorded, never serviced.
            w_fault_set = overflowE | w_sys_ok;
            if (eretD && !stallD) w_state_nxt = ERET;
         end
         ERET:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cause  <= CAUSE_NONE;
         r_ack    <= '0;
         r_guard  <= '0;
         r_kfault <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cause  <= w_cause_nxt;
         r_ack    <= w_ack_nxt;
         r_kfault <= r_kfault | w_fault_set;
         if (r_state == ERET) begin
            r_guard <= GW'(ERET_GUARD);
         end else if (r_state == IDLE && r_guard != '0) begin
            r_guard <= r_guard - GW'(1);
         end
      end
   end

   assign cause_write  = (r_state == TAKE);
   assign exit_kernel  = (r_state == ERET);
   assign int_cause    = r_cause;
   assign irq_ack      = r_ack;
   assign flushF       = cause_write | exit_kernel;
   assign flushD       = cause_write | exit_kernel;
   assign flushE       = cause_write;
   assign pc_redirect  = cause_write | exit_kernel;
   assign pc_target    = cause_write ? VECTOR_ADDR : (exit_kernel ? epc : 32'h0);
   assign kernel_fault = r_kfault;

endmodule

`default_nettype wire

// File: tb/tb_exception_ctrl.sv
// ============================================================================
// Module : tb_exception_ctrl
// Brief  : Directed scenarios plus randomized run against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_exception_ctrl;

   localparam int          IRQ_W = 4;
   localparam logic [31:0] VEC   = 32'h0000_0080;
   localparam int          GUARD = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [IRQ_W-1:0] irq;
   logic [IRQ_W-1:0] irq_ack;
   logic             overflowE, syscallD, eretD, stallD, kernel_mode;
   logic [31:0]      epc;
   logic             cause_write;
   logic [2:0]       int_cause;
   logic             exit_kernel, flushF, flushD, flushE, pc_redirect;
   logic [31:0]      pc_target;
   logic             kernel_fault;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   exception_ctrl #(.IRQ_W(IRQ_W), .VECTOR_ADDR(VEC), .ERET_GUARD(GUARD)) dut (
      .clk          (clk),
      .reset        (reset),
      .irq          (irq),
      .irq_ack      (irq_ack),
      .overflowE    (overflowE),
      .syscallD     (syscallD),
      .eretD        (eretD),
      .stallD       (stallD),
      .kernel_mode  (kernel_mode),
      .epc          (epc),
      .cause_write  (cause_write),
      .int_cause    (int_cause),
      .exit_kernel  (exit_kernel),
      .flushF       (flushF),
      .flushD       (flushD),
      .flushE       (flushE),
      .pc_redirect  (pc_redirect),
      .pc_target    (pc_target),
      .kernel_fault (kernel_fault)
   );

   function automatic logic [45:0] outs();
      return {cause_write, int_cause, exit_kernel, flushF, flushD, flushE,
              pc_redirect, kernel_fault, irq_ack, pc_target};
   endfunction

   function automatic logic [45:0] pack(input logic cw, input logic [2:0] cause,
                                        input logic ek, input logic ff, input logic fd,
                                        input logic fe, input logic red, input logic kf,
                                        input logic [IRQ_W-1:0] ack, input logic [31:0] tgt);
      return {cw, cause, ek, ff, fd, fe, red, kf, ack, tgt};
   endfunction

   task automatic idle_inputs();
      irq = '0; overflowE = 0; syscallD = 0; eretD = 0; stallD = 0; epc = '0;
   endtask

   // One clock; also emulates CP0 flipping kernel_mode after cause_write / exit_kernel.
   task automatic tick();
      logic cw_prev, ek_prev;
      cw_prev = cause_write;
      ek_prev = exit_kernel;
      @(posedge clk);
      #1;
      if (reset)        kernel_mode = 1'b1;
      else if (cw_prev) kernel_mode = 1'b0;
      else if (ek_prev) kernel_mode = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      irq = 4'b1111;
      overflowE = 1;
      reset = 1'b1;
      tick();
      tick();
      vectors++;
      if (outs() !== 46'h0) begin
         miscompares++;
         $display("FAIL reset_state: got %h expected %h", outs(), 46'h0);
      end
      idle_inputs();
      reset = 1'b0;
   endtask

   task automatic test_overflow_eret();
      logic [45:0] exp;
      int ack_at;
      do_reset();
      overflowE = 1; tick(); overflowE = 0;
      exp = pack(1, 3'b001, 0, 1, 1, 1, 1, 0, 4'b0, VEC);
      vectors++;
      if (outs() !== exp) begin
         miscompares++; $display("FAIL ovf_take: got %h expected %h", outs(), exp);
      end
      tick();
      vectors++;
      if (outs() !== 46'h0) begin
         miscompares++; $display("FAIL ovf_kwait: got %h expected %h", outs(), 46'h0);
      end
      tick();
      eretD = 1; epc = 32'h0000_0400; tick(); eretD = 0;
      exp = pack(0, 3'b000, 1, 1, 1, 0, 1, 0, 4'b0, 32'h0000_0400);
      vectors++;
      if (outs() !== exp) begin
         miscompares++; $display("FAIL eret_pulse: got %h expected %h", outs(), exp);
      end
      tick(); irq = 4'b0001; tick(); irq = '0;
      ack_at = 0;
      for (int k = 2; k < 12 && ack_at == 0; k++) begin
         if (irq_ack !== 4'b0000) ack_at = k;
         else tick();
      end
      vectors++;
      if (ack_at != GUARD + 2 || irq_ack !== 4'b0001) begin
         miscompares++;
         $display("FAIL irq_guard_latency: got ack %b at +%0d expected 0001 at +%0d",
                  irq_ack, ack_at, GUARD + 2);
      end
   endtask

   task automatic test_ovf_and_syscall();
      logic [45:0] exp;
      int pulses;
      do_reset();
      overflowE = 1; syscallD = 1; tick(); overflowE = 0; syscallD = 0;
      exp = pack(1, 3'b001, 0, 1, 1, 1, 1, 0, 4'b0, VEC);
      vectors++;
      if (outs() !== exp) begin
         miscompares++; $display("FAIL ovf_sys_take: got %h expected %h", outs(), exp);
      end
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (cause_write === 1'b1) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++; $display("FAIL ovf_sys_single: got %0d extra pulses expected 0", pulses);
      end
   endtask

   task automatic test_irq_pending();
      logic [45:0] exp;
      int ack_at;
      do_reset();
      irq = 4'b0110; tick(); irq = '0;
      exp = pack(1, 3'b011, 0, 1, 1, 1, 1, 0, 4'b0010, VEC);
      vectors++;
      if (outs() !== exp) begin
         miscompares++; $display("FAIL irq_first: got %h expected %h", outs(), exp);
      end
      tick(); tick();
      eretD = 1; epc = 32'h0000_1234; tick(); eretD = 0;
      exp = pack(0, 3'b000, 1, 1, 1, 0, 1, 0, 4'b0, 32'h0000_1234);
      vectors++;
      if (outs() !== exp) begin
         miscompares++; $display("FAIL irq_eret: got %h expected %h", outs(), exp);
      end
      ack_at = 0;
      for (int k = 0; k < 12 && ack_at == 0; k++) begin
         if (irq_ack !== 4'b0000) ack_at = k;
         else tick();
      end
      vectors++;
      if (ack_at != GUARD + 2 || irq_ack !== 4'b0100 || int_cause !== 3'b011) begin
         miscompares++;
         $display("FAIL irq_second: got ack %b cause %b at +%0d expected 0100 011 at +%0d",
                  irq_ack, int_cause, ack_at, GUARD + 2);
      end
   endtask

   task automatic test_stall();
      logic [45:0] exp;
      do_reset();
      syscallD = 1; stallD = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (cause_write !== 1'b0) begin
            miscompares++; $display("FAIL stall_defer%0d: got %b expected 0", k, cause_write);
         end
      end
      stallD = 0; tick(); syscallD = 0;
      exp = pack(1, 3'b010, 0, 1, 1, 1, 1, 0, 4'b0, VEC);
      vectors++;
      if (outs() !== exp) begin
         miscompares++; $display("FAIL stall_release: got %h expected %h", outs(), exp);
      end
   endtask

   task automatic test_kfault_reset();
      logic [45:0] exp;
      int seen;
      do_reset();
      overflowE = 1; tick(); overflowE = 0;
      tick(); tick();
      irq = 4'b0001; syscallD = 1; tick(); irq = '0; syscallD = 0;
      exp = pack(0, 3'b000, 0, 0, 0, 0, 0, 1, 4'b0, 32'h0);
      vectors++;
      if (outs() !== exp) begin
         miscompares++; $display("FAIL kfault_set: got %h expected %h", outs(), exp);
      end
      tick(); tick();
      vectors++;
      if (outs() !== exp) begin
         miscompares++; $display("FAIL kfault_sticky: got %h expected %h", outs(), exp);
      end
      eretD = 1; tick(); eretD = 0;
      tick();
      overflowE = 1; tick(); overflowE = 0;
      exp = pack(1, 3'b001, 0, 1, 1, 1, 1, 1, 4'b0, VEC);
      vectors++;
      if (outs() !== exp) begin
         miscompares++; $display("FAIL take_with_fault: got %h expected %h", outs(), exp);
      end
      reset = 1; tick(); reset = 0;
      vectors++;
      if (outs() !== 46'h0) begin
         miscompares++; $display("FAIL reset_mid_take: got %h expected %h", outs(), 46'h0);
      end
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (irq_ack !== 4'b0000) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++; $display("FAIL pending_cleared: got %0d acks expected 0", seen);
      end
   endtask

   task automatic test_random();
      logic [IRQ_W-1:0] pend, req, e_ack, n_ack;
      logic [2:0]       e_cause, n_cause;
      logic             e_cw, e_ek, n_cw, n_ek, fault;
      int               guard, n_guard, phase, n_phase, pick;
      logic [45:0]      exp;
      do_reset();
      pend = '0; e_ack = '0; e_cause = '0; e_cw = 0; e_ek = 0; fault = 0;
      guard = 0; phase = 0;   // phase: 0 user, 1 handler entered, 2 handler running
      for (int c = 0; c < 3000; c++) begin
         overflowE = ($urandom_range(0, 19) == 0);
         syscallD  = ($urandom_range(0, 9) == 0);
         eretD     = ($urandom_range(0, 5) == 0);
         stallD    = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < IRQ_W; i++) irq[i] = ($urandom_range(0, 23) == 0);
         epc = $urandom & 32'hFFFF_FFFC;
         #1;
         exp = pack(e_cw, e_cause, e_ek, e_cw | e_ek, e_cw | e_ek, e_cw, e_cw | e_ek,
                    fault, e_ack, e_cw ? VEC : (e_ek ? epc : 32'h0));
         vectors++;
         if (outs() !== exp) begin
            miscompares++;
            $display("FAIL random_c%0d: got %h expected %h", c, outs(), exp);
         end
         req = pend | irq;
         n_cw = 0; n_ek = 0; n_cause = 3'b000; n_ack = '0;
         n_guard = guard; n_phase = phase;
         if (e_cw) begin
            n_phase = 1;
         end else if (e_ek) begin
            n_phase = 0; n_guard = GUARD;
         end else if (phase == 1) begin
            if (!kernel_mode) n_phase = 2;
         end else if (phase == 2) begin
            if (overflowE || (syscallD && !stallD)) fault = 1;
            if (eretD && !stallD) n_ek = 1;
         end else begin
            if (guard > 0) n_guard = guard - 1;
            if (overflowE) begin
               n_cw = 1; n_cause = 3'b001;
            end else if (syscallD && !stallD) begin
               n_cw = 1; n_cause = 3'b010;
            end else if (kernel_mode && guard == 0 && !stallD && req != 0) begin
               pick = 0;
               for (int i = IRQ_W - 1; i >= 0; i--) if (req[i]) pick = i;
               n_cw = 1; n_cause = 3'b011; n_ack = IRQ_W'(1) << pick;
            end else if (eretD && !kernel_mode && !stallD) begin
               n_ek = 1;
            end
         end
         pend = req & ~e_ack;
         e_cw = n_cw; e_ek = n_ek; e_cause = n_cause; e_ack = n_ack;
         guard = n_guard; phase = n_phase;
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      kernel_mode = 1'b1;
      idle_inputs();
      test_reset();
      test_overflow_eret();
      test_ovf_and_syscall();
      test_irq_pending();
      test_stall();
      test_kfault_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
Exception/interrupt controller that drives the cause-recording side of coprocessor 0. It arbitrates E-stage overflow, D-stage syscall and external IRQ lines. For the winning event it issues a one-cycle cause_write/int_cause pulse, flushes the pipeline and redirects fetch to the kernel vector. It also executes eret (exit_kernel pulse, redirect to EPC), and sits beside the hazard unit between the pipeline and coprocessor 0.

Parameters:
IRQ_W, 4, number of external interrupt request lines
VECTOR_ADDR, 32'h0000_0080, kernel entry PC
ERET_GUARD, 2, cycles after eret during which IRQs are not accepted

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
irq  in  IRQ_W  level-sensitive external requests, synchronous to clk
irq_ack  out  IRQ_W  one-hot, pulses the cycle an IRQ is taken
overflowE  in  1  arithmetic overflow of instruction in E
syscallD  in  1  syscall decoded in D
eretD  in  1  eret decoded in D
stallD  in  1  D stage stalled by hazard unit
kernel_mode  in  1  from coprocessor 0; 0 = kernel, 1 = user
epc  in  32  current EPC from coprocessor 0
cause_write  out  1  one-cycle pulse to coprocessor 0
int_cause  out  3  cause code, valid with cause_write, else 0
exit_kernel  out  1  one-cycle pulse to coprocessor 0 on eret
flushF, flushD, flushE  out  1 each  pipeline flush
pc_redirect  out  1  fetch takes pc_target next edge
pc_target  out  32  VECTOR_ADDR or epc
kernel_fault  out  1  sticky: exception raised while in kernel

Behaviour:
- Reset: state IDLE. All pulses 0, int_cause 0, pc_target 0, kernel_fault 0, pending 0, guard counter 0.
- Cause codes: 3'b001 overflow (EPC = pcF-8), 3'b010 syscall (pcF-4), 3'b011 external IRQ (pcF-4), 3'b000 none.
- pending[i] sets on irq[i]. It clears only on irq_ack[i] or reset, so an IRQ deasserted before service is still taken.
- Priority (same cycle): overflowE > syscallD > lowest-index pending IRQ.
- syscallD and IRQ acceptance require stallD = 0. While stalled they are deferred; overflowE is never deferred.
- IRQ acceptance requires kernel_mode = 1 and guard counter = 0.
- States:
  - IDLE: on an accepted event go to TAKE. On eretD with kernel_mode = 0 and stallD = 0 go to ERET. eretD in user mode is ignored (treated as nop).
  - TAKE (1 cycle): cause_write = 1, int_cause = code, flushF/D/E = 1, pc_redirect = 1, pc_target = VECTOR_ADDR, irq_ack set if the event is an IRQ. Next state is KWAIT.
  - KWAIT: waits for kernel_mode = 0, which arrives the cycle after cause_write. All new events are ignored here. Next state is KERNEL.
  - KERNEL: IRQs stay pending. overflowE or syscallD sets kernel_fault with no cause_write and no redirect. eretD with stallD = 0 goes to ERET.
  - ERET (1 cycle): exit_kernel = 1, flushF/D = 1, pc_redirect = 1, pc_target = epc, guard counter loads ERET_GUARD. Next state is IDLE.
- Guard counter decrements to 0 in IDLE. It blocks only IRQs, not overflow or syscall.
- Latency: event sampled at edge N, TAKE outputs during cycle N+1, vector fetched at edge N+2.
- Simultaneous overflowE and syscallD: only overflow is recorded. The syscall is flushed and re-executes after eret.
- Reset mid-TAKE/ERET: pulses drop the same edge, pending cleared, state IDLE.
- kernel_fault clears only on reset.

Decomposition:
- Package exc_pkg holds:
  - cause codes CAUSE_NONE/OVF/SYSCALL/IRQ as a 3-bit typedef cause_t;
  - state enum exc_state_t {IDLE, TAKE, KWAIT, KERNEL, ERET};
  - VECTOR_ADDR default.
- One natural sub-module, irq_pending: pending register, lowest-index priority pick, ack clear.

Test Plan:
- overflowE=1 in IDLE, user mode → next cycle cause_write=1, int_cause=3'b001, flushF/D/E=1, pc_target=32'h80; then KWAIT→KERNEL once kernel_mode=0.
- overflowE=1 and syscallD=1 same cycle → int_cause=3'b001 only, a single cause_write pulse.
- irq=4'b0110 one cycle, user mode → irq_ack=4'b0010, int_cause=3'b011; after eret and 2 guard cycles → irq_ack=4'b0100 with pending bit 2 still held.
- In KERNEL, eretD=1 with epc=32'h0000_0400 → exit_kernel=1, pc_target=32'h400, flushF/D=1; irq[0] asserted the next cycle is acked no earlier than 3 cycles after exit_kernel.
- syscallD=1 with stallD=1 for 3 cycles → no cause_write; it occurs the cycle after stallD drops, int_cause=3'b010.
- syscallD in KERNEL → kernel_fault=1 sticky, no cause_write; reset asserted during TAKE → all outputs 0 next edge.
